// File: rtl/lamp_alarm_ctrl.sv
// Lamp status alarm controller: persistence-filtered level decode, alarm FSM
// with acknowledge/latch handling, registered lamp/buzzer drive and event count.
module lamp_alarm_ctrl #(
    parameter int unsigned PERSIST   = 4,
    parameter int unsigned BLINK_DIV = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ok,
    input  logic       alert,
    input  logic       danger,
    input  logic       ack,
    output logic [1:0] state,
    output logic       lamp_green,
    output logic       lamp_amber,
    output logic       lamp_red,
    output logic       buzzer,
    output logic [7:0] event_cnt
);

    localparam int unsigned RUN_W   = 4;
    localparam int unsigned BLINK_W = 8;
    localparam int unsigned CNT_W   = 8;

    typedef enum logic [1:0] {
        ST_OK      = 2'b00,
        ST_ALERT   = 2'b01,
        ST_DANGER  = 2'b10,
        ST_LATCHED = 2'b11
    } state_t;

    state_t             dec_c;
    state_t             cand_q;
    state_t             filt_q;
    state_t             filt_next_c;
    logic [RUN_W-1:0]   run_q;
    logic               accept_c;

    state_t             state_q;
    state_t             state_next_c;
    logic               acked_q;
    logic               acked_next_c;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_next_c;

    logic               ack_q;
    logic               ack_rise_c;

    logic [BLINK_W-1:0] blink_cnt_q;
    logic               phase_q;

    logic               green_c;
    logic               amber_c;
    logic               red_c;
    logic               buzzer_c;
    logic               green_q;
    logic               amber_q;
    logic               red_q;
    logic               buzzer_q;

    // Priority decode; no flag set at all is treated as an input fault (ALERT).
    always_comb begin
        dec_c = ST_ALERT;
        if (danger) begin
            dec_c = ST_DANGER;
        end else if (alert) begin
            dec_c = ST_ALERT;
        end else if (ok) begin
            dec_c = ST_OK;
        end
    end

    // The reload edge counts as the first edge of a new run.
    always_comb begin
        accept_c = 1'b0;
        if (dec_c != cand_q) begin
            accept_c = (PERSIST == 1);
        end else begin
            accept_c = (run_q != RUN_W'(PERSIST)) &&
                       ((run_q + RUN_W'(1)) == RUN_W'(PERSIST));
        end
        filt_next_c = accept_c ? dec_c : filt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand_q <= ST_ALERT;
            filt_q <= ST_ALERT;
            run_q  <= '0;
        end else begin
            filt_q <= filt_next_c;
            if (dec_c != cand_q) begin
                cand_q <= dec_c;
                run_q  <= RUN_W'(1);
            end else if (run_q != RUN_W'(PERSIST)) begin
                run_q <= run_q + RUN_W'(1);
            end
        end
    end

    assign ack_rise_c = ack & ~ack_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_q <= 1'b0;
        end else begin
            ack_q <= ack;
        end
    end

    // The FSM acts on the level the filter accepts at this same edge.
    always_comb begin
        state_next_c = state_q;
        acked_next_c = acked_q;
        cnt_next_c   = cnt_q;
        if ((filt_next_c == ST_DANGER) && (state_q != ST_DANGER)) begin
            state_next_c = ST_DANGER;
            acked_next_c = 1'b0;
            if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_next_c = cnt_q + CNT_W'(1);
            end
        end else begin
            case (state_q)
                ST_DANGER: begin
                    if (filt_next_c != ST_DANGER) begin
                        state_next_c = (acked_q | ack_rise_c) ? filt_next_c : ST_LATCHED;
                        acked_next_c = 1'b0;
                    end else if (ack_rise_c) begin
                        acked_next_c = 1'b1;
                    end
                end
                ST_LATCHED: begin
                    if (ack_rise_c) begin
                        state_next_c = filt_next_c;
                    end
                end
                default: begin
                    state_next_c = filt_next_c;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_ALERT;
            acked_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_next_c;
            acked_q <= acked_next_c;
            cnt_q   <= cnt_next_c;
        end
    end

    // Free-running blink divider.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
        end else if (blink_cnt_q == BLINK_W'(BLINK_DIV - 1)) begin
            blink_cnt_q <= '0;
            phase_q     <= ~phase_q;
        end else begin
            blink_cnt_q <= blink_cnt_q + BLINK_W'(1);
        end
    end

    always_comb begin
        green_c  = 1'b0;
        amber_c  = 1'b0;
        red_c    = 1'b0;
        buzzer_c = 1'b0;
        case (state_q)
            ST_OK:      green_c = 1'b1;
            ST_ALERT:   amber_c = 1'b1;
            ST_DANGER: begin
                red_c    = acked_q ? 1'b1 : phase_q;
                buzzer_c = ~acked_q;
            end
            default:    red_c = phase_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            green_q  <= 1'b0;
            amber_q  <= 1'b1;
            red_q    <= 1'b0;
            buzzer_q <= 1'b0;
        end else begin
            green_q  <= green_c;
            amber_q  <= amber_c;
            red_q    <= red_c;
            buzzer_q <= buzzer_c;
        end
    end

    assign state      = state_q;
    assign lamp_green = green_q;
    assign lamp_amber = amber_q;
    assign lamp_red   = red_q;
    assign buzzer     = buzzer_q;
    assign event_cnt  = cnt_q;

endmodule

// File: tb/tb_lamp_alarm_ctrl.sv
// Scoreboard bench for lamp_alarm_ctrl: a window/rule-based reference model
// pushes expected outputs per edge; a negedge monitor pops and compares.
module tb_lamp_alarm_ctrl;

    localparam int unsigned P  = 4;
    localparam int unsigned BD = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ok = 1'b0;
    logic       alert = 1'b0;
    logic       danger = 1'b0;
    logic       ack = 1'b0;
    logic [1:0] state;
    logic       lamp_green;
    logic       lamp_amber;
    logic       lamp_red;
    logic       buzzer;
    logic [7:0] event_cnt;

    lamp_alarm_ctrl #(.PERSIST(P), .BLINK_DIV(BD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ok         (ok),
        .alert      (alert),
        .danger     (danger),
        .ack        (ack),
        .state      (state),
        .lamp_green (lamp_green),
        .lamp_amber (lamp_amber),
        .lamp_red   (lamp_red),
        .buzzer     (buzzer),
        .event_cnt  (event_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] st;
        logic       g;
        logic       a;
        logic       r;
        logic       b;
        logic [7:0] cnt;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;

    // Reference model: levels 0 OK, 1 ALERT, 2 DANGER, 3 LATCHED.
    int   m_state, m_acked, m_cnt, m_ackp, m_edges, m_filt;
    int   hist[$];

    task automatic model_reset();
        m_state = 1; m_acked = 0; m_cnt = 0; m_ackp = 0; m_edges = 0; m_filt = 1;
        hist.delete();
    endtask

    task automatic model_edge();
        int   dec, ns, na, ph;
        bit   same, ar;
        exp_t e;
        // Outputs seen after this edge reflect the state held before it.
        ph = (m_edges / BD) % 2;
        e.g = (m_state == 0);
        e.a = (m_state == 1);
        e.r = (m_state == 2) ? (m_acked ? 1'b1 : 1'(ph)) : (m_state == 3) ? 1'(ph) : 1'b0;
        e.b = (m_state == 2) && !m_acked;

        dec = danger ? 2 : alert ? 1 : ok ? 0 : 1;
        hist.push_back(dec);
        if (hist.size() > P) void'(hist.pop_front());
        if (hist.size() == P) begin
            same = 1'b1;
            foreach (hist[i]) if (hist[i] != dec) same = 1'b0;
            if (same) m_filt = dec;
        end
        ar = ack && !m_ackp;
        m_ackp = ack;

        ns = m_state; na = m_acked;
        if (m_filt == 2 && m_state != 2) begin
            ns = 2; na = 0;
            if (m_cnt < 255) m_cnt++;
        end else if (m_state == 2) begin
            if (m_filt != 2) begin
                ns = (m_acked != 0 || ar) ? m_filt : 3;
                na = 0;
            end else if (ar) begin
                na = 1;
            end
        end else if (m_state == 3) begin
            if (ar) ns = m_filt;
        end else begin
            ns = m_filt;
        end
        m_state = ns; m_acked = na; m_edges++;
        e.st  = 2'(m_state);
        e.cnt = 8'(m_cnt);
        q.push_back(e);
    endtask

    task automatic step(input logic o, input logic a, input logic d, input logic k);
        ok = o; alert = a; danger = d; ack = k;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic steps(input int n, input logic o, input logic a, input logic d, input logic k);
        for (int i = 0; i < n; i++) step(o, a, d, k);
    endtask

    // Asynchronous reset: outputs must be at reset values before any clock edge.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        total++;
        if (state !== 2'b01 || lamp_green !== 1'b0 || lamp_amber !== 1'b1 ||
            lamp_red !== 1'b0 || buzzer !== 1'b0 || event_cnt !== 8'd0) begin
            bad++;
            $display("FAIL async_reset got st=%b g=%b a=%b r=%b b=%b cnt=%0d want st=01 g=0 a=1 r=0 b=0 cnt=0",
                     state, lamp_green, lamp_amber, lamp_red, buzzer, event_cnt);
        end
        q.delete();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && q.size() > 0) begin
            e = q.pop_front();
            total++;
            if (state !== e.st || lamp_green !== e.g || lamp_amber !== e.a ||
                lamp_red !== e.r || buzzer !== e.b || event_cnt !== e.cnt) begin
                bad++;
                $display("FAIL edge_check t=%0t got st=%b g=%b a=%b r=%b b=%b cnt=%0d want st=%b g=%b a=%b r=%b b=%b cnt=%0d",
                         $time, state, lamp_green, lamp_amber, lamp_red, buzzer, event_cnt,
                         e.st, e.g, e.a, e.r, e.b, e.cnt);
            end
        end
    end

    initial begin
        int lvl, dur;
        logic k;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        steps(8, 1, 0, 0, 0);                 // reset release, ok held
        steps(3, 1, 0, 1, 0);                 // short danger glitch
        steps(6, 1, 0, 0, 0);
        steps(24, 0, 0, 1, 0);                // unacked danger, blinking
        steps(2, 0, 0, 1, 1);                 // ack -> solid red
        steps(6, 0, 0, 1, 0);
        steps(6, 1, 0, 0, 0);                 // acked clear -> OK
        steps(6, 0, 0, 1, 0);
        steps(8, 1, 0, 0, 0);                 // unacked clear -> LATCHED
        step(1, 0, 0, 1);                     // ack releases LATCHED
        steps(3, 1, 0, 0, 0);
        steps(6, 0, 0, 1, 0);
        steps(3, 1, 0, 0, 0);
        step(1, 0, 0, 1);                     // ack on the accepting edge
        steps(4, 1, 0, 0, 0);
        steps(6, 0, 0, 0, 0);                 // input fault -> ALERT
        steps(6, 0, 1, 0, 0);
        steps(5, 0, 0, 1, 1);                 // ack already high at danger entry
        steps(6, 1, 0, 0, 1);

        for (int i = 0; i < 250; i++) begin
            lvl = $urandom_range(0, 3);
            dur = $urandom_range(1, 8);
            for (int j = 0; j < dur; j++) begin
                k = ($urandom_range(0, 7) == 0);
                case (lvl)
                    0: step(1, 0, 0, k);
                    1: step(1, 1, 0, k);
                    2: step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1, k);
                    default: step(0, 0, 0, k);
                endcase
            end
        end

        steps(8, 1, 0, 0, 0);
        for (int i = 0; i < 300; i++) begin   // saturation of event count
            steps(P, 0, 0, 1, 0);
            steps(P, 1, 0, 0, 0);
        end
        steps(P + 2, 0, 0, 1, 0);
        do_reset();                           // reset mid-DANGER
        steps(8, 0, 0, 1, 0);
        steps(P + 3, 1, 0, 0, 0);
        do_reset();                           // reset mid-LATCHED
        steps(8, 1, 0, 0, 0);

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
